// File: rtl/adc_pkg.sv
// Shared types and default constants for the serial ADC reader.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        QUIET
    } state_t;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_LEAD_BITS = 0;
    localparam int DEF_DATA_BITS = 16;
    localparam int DEF_QUIET_CYC = 4;
    localparam int WORD_W        = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: divides clk_in and toggles sclk, flagging each edge it drives.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(CLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = en && (cnt == CNT_W'(CLK_DIV - 1));
    // rise/fall mark the clk_in edge at which sclk is driven to its new level
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (clr) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (en) begin
            if (tick) begin
                cnt  <= '0;
                sclk <= ~sclk;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_reader.sv
// Serial-read controller for the external ADC: frames cs/sclk, shifts in sdo MSB first
// and presents the received word on dato with a one-cycle valid strobe.
module adc_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int LEAD_BITS = DEF_LEAD_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int QUIET_CYC = DEF_QUIET_CYC
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        ctrl,
    input  logic        sdo,
    output logic        cs,
    output logic        sclk,
    output logic [15:0] dato,
    output logic        valid,
    output logic        busy
);

    localparam int FRAME_BITS = LEAD_BITS + DATA_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int QCNT_W     = cnt_width(QUIET_CYC);

    state_t                  state;
    state_t                  next_state;
    logic                    start;
    logic                    sclk_en;
    logic                    sclk_clr;
    logic                    rise;
    logic                    fall;
    logic                    last_bit;
    logic                    quiet_last;
    logic [BIT_W-1:0]        bit_cnt;
    logic [QCNT_W-1:0]       quiet_cnt;
    logic [FRAME_BITS-1:0]   shreg;

    assign sclk_en    = (state == SETUP) || (state == SHIFT);
    assign sclk_clr   = (state == IDLE);
    assign start      = (state == IDLE) && !ctrl;
    assign last_bit   = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign quiet_last = (quiet_cnt == QCNT_W'(QUIET_CYC - 1));

    adc_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk_in(clk_in),
        .rst   (rst),
        .en    (sclk_en),
        .clr   (sclk_clr),
        .sclk  (sclk),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ctrl is only looked at in IDLE, so requests during a frame are dropped
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!ctrl) next_state = SETUP;
            SETUP:   if (fall) next_state = SHIFT;
            SHIFT:   if (rise && last_bit) next_state = DONE;
            DONE:    next_state = QUIET;
            QUIET:   if (quiet_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cs        <= 1'b1;
            busy      <= 1'b0;
            valid     <= 1'b0;
            dato      <= '0;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
        end else begin
            valid <= (state == DONE);
            if (start) begin
                cs      <= 1'b0;
                busy    <= 1'b1;
                bit_cnt <= '0;
            end else if (state == DONE) begin
                cs        <= 1'b1;
                dato      <= WORD_W'(shreg[DATA_BITS-1:0]);
                quiet_cnt <= '0;
            end else if ((state == QUIET) && quiet_last) begin
                busy <= 1'b0;
            end
            if (rise) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == QUIET) begin
                quiet_cnt <= quiet_cnt + 1'b1;
            end
        end
    end

    // Every frame refills all FRAME_BITS, so stale content never reaches dato;
    // lead bits end up above DATA_BITS and are dropped when dato is loaded.
    always_ff @(posedge clk_in) begin
        if (rise) begin
            shreg <= FRAME_BITS'({shreg, sdo});
        end
    end

endmodule

// File: doc/adc_reader.md
# adc_reader

Serial-read controller for the board's external SPI-style ADC; the receive-side counterpart of `Dac_ctrl`. On an active-low `ctrl` request it asserts chip select, generates `sclk` from `clk_in`, and shifts the converter's MSB-first data line into a parallel word. It then presents the word with a one-cycle `valid` strobe. It sits between the ADC pins and the EPP register file, using the same `ctrl`/`dato` conventions as `Dac_ctrl`.

## Interface
- `CLK_DIV`, 2: `clk_in` cycles per `sclk` half-period; must be at least 1.
- `LEAD_BITS`, 0: leading frame bits clocked in and discarded (converter zero/track bits).
- `DATA_BITS`, 16: data bits kept, MSB first, range 1..16.
- `QUIET_CYC`, 4: minimum `clk_in` cycles `cs` stays high between frames.
- `clk_in` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ctrl` in 1: start request, active-low, level-sensitive, synchronous to `clk_in`.
- `sdo` in 1: serial data from the ADC.
- `cs` out 1: chip select to the ADC, active-low.
- `sclk` out 1: serial clock to the ADC; idles high.
- `dato` out 16: last received word, right-justified, upper bits zero when `DATA_BITS` < 16.
- `valid` out 1: one-cycle strobe; `dato` is new in that cycle.
- `busy` out 1: high from start until the quiet interval ends.

## Operation
- **Reset values:** `cs`=1, `sclk`=1, `dato`=0, `valid`=0, `busy`=0, state IDLE. Assertion mid-frame aborts at once: `cs` and `sclk` go high asynchronously, partial data is discarded, and `dato` is cleared.
- **States:** IDLE → SETUP → SHIFT → DONE → QUIET → IDLE.
- **IDLE:** if `ctrl`=0 at a clock edge, go to SETUP, drive `cs`=0, set `busy`=1, clear the bit counter.
- **SETUP:** hold `cs` low with `sclk` high for `CLK_DIV` cycles, then drive `sclk` low and enter SHIFT.
- **SHIFT:** `sclk` toggles every `CLK_DIV` cycles. The ADC changes `sdo` on falling edges. The block samples `sdo` on the clock edge at which it drives `sclk` 0→1 and left-shifts it into the shift register.
- **Frame length:** N = `LEAD_BITS` + `DATA_BITS` rising edges. After the N-th rising edge, `sclk` stays high and the block goes to DONE.
- **DONE:** one cycle. `cs`=1, `dato` gets the low `DATA_BITS` of the shift register (lead bits drop out naturally), `valid`=1.
- **QUIET:** `cs`=1 for `QUIET_CYC` cycles, then IDLE and `busy`=0.
- **`ctrl` while busy:** a low `ctrl` in any state other than IDLE is ignored and not queued. Holding `ctrl` low gives back-to-back frames, each separated by `QUIET_CYC` + 1 idle-high cycles of `cs`.
- **Counter widths:** the divider counter is `$clog2(CLK_DIV)` bits with a minimum of 1. The bit counter is `$clog2(LEAD_BITS+DATA_BITS+1)` bits. Neither counter wraps inside a frame.

## Timing
- Let E0 be the edge that samples `ctrl`=0 in IDLE. `cs` falls after E0.
- First `sclk` fall occurs after E0 + `CLK_DIV`.
- k-th rising edge (sample point), k = 1..N: E0 + 2k·`CLK_DIV`.
- `valid`=1 and new `dato`, with `cs` high, in the cycle after E0 + 2N·`CLK_DIV` + 1. With defaults that is 65 cycles after E0.
- `busy` falls after E0 + 2N·`CLK_DIV` + 1 + `QUIET_CYC`. The earliest next start is the following edge.
- `dato` holds its value between `valid` strobes.

## Structure
- **Shared package `adc_pkg`:** state enum (IDLE, SETUP, SHIFT, DONE, QUIET) and default parameter constants.
- **Sub-module `adc_sclk_gen`:** divider plus `sclk` toggle, with enable/clear inputs and `rise`/`fall` one-cycle pulses. The top level holds the FSM, bit counter and shift register.

## Test plan
- **Basic read:** defaults, ADC model drives 0xCAAA MSB-first on `sclk` falls, single-cycle `ctrl` low → exactly 16 `sclk` rises, `cs` low throughout, `valid` one cycle 65 cycles after E0, `dato`=0xCAAA.
- **Lead bits:** `LEAD_BITS`=4, `DATA_BITS`=12, model sends 4'b0000 then 0xABC → 16 rises, `dato`=0x0ABC.
- **Reset mid-frame:** `rst` pulse at cycle 30 of a frame → `cs`=1 and `sclk`=1 immediately, `dato`=0, no `valid`. A following `ctrl` pulse reads 0x1234 correctly.
- **Request while busy:** `ctrl` pulses at cycles 10 and 40 of a frame → exactly one `valid`, and no `cs` fall until QUIET ends.
- **Continuous mode:** `ctrl` held low for 3 frames → 3 `valid` strobes 70 cycles apart with defaults, `cs` high for 5 cycles between frames.
- **Minimum divider:** `CLK_DIV`=1, data 0xFFFF then 0x0001 → correct words, `valid` 33 cycles after each E0.
